// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: CPU peripheral-bus slave in front of a byte-level UART RX/TX core.
// Optional feature: define UART_BRIDGE_ECHO_EN to retransmit every received byte while TX is idle.
`default_nettype none

module uart_bus_bridge #(
  parameter int DATA_WIDTH = 16,
  parameter int NB_BITS    = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cs,
  input  logic                  i_w_r,
  input  logic [ADDR_WIDTH-1:0] i_addr_bus,
  inout  wire  [DATA_WIDTH-1:0] io_data_bus,
  input  logic [NB_BITS-1:0]    i_rx_data,
  input  logic                  i_rx_done,
  output logic [NB_BITS-1:0]    o_tx_data,
  output logic                  o_tx_start,
  input  logic                  i_tx_done,
  output logic                  o_cpu_enable
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_WAIT  = 2'd2
  } tx_state_t;

  tx_state_t            tx_state, tx_state_next;
  logic [NB_BITS-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 rx_overrun, tx_drop;
  logic                 tx_load;
  logic [NB_BITS-1:0]   tx_load_val;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] status;

  wire rd_cycle   = i_cs & ~i_w_r;
  wire wr_cycle   = i_cs & i_w_r;
  wire sel_rx     = (i_addr_bus == ADDR_WIDTH'(0));
  wire sel_status = (i_addr_bus == ADDR_WIDTH'(1));
  wire sel_tx     = (i_addr_bus == ADDR_WIDTH'(2));

  wire fifo_empty = (count == CNT_W'(0));
  wire fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  wire pop        = rd_cycle & sel_rx & ~fifo_empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  wire push       = i_rx_done & (~fifo_full | pop);
  wire ovr_set    = i_rx_done & fifo_full & ~pop;
  wire tx_wr      = wr_cycle & sel_tx;
  wire drop_set   = tx_wr & (tx_state != TX_IDLE);
  wire ovr_clr    = wr_cycle & sel_status & io_data_bus[3];
  wire drop_clr   = wr_cycle & sel_status & io_data_bus[4];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wr_ptr] <= i_rx_data;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rx_overrun   <= 1'b0;
      tx_drop      <= 1'b0;
      o_cpu_enable <= 1'b0;
    end else begin
      rx_overrun <= ovr_set  | (rx_overrun & ~ovr_clr);
      tx_drop    <= drop_set | (tx_drop & ~drop_clr);
      if (i_rx_done) o_cpu_enable <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      tx_state  <= TX_IDLE;
      o_tx_data <= '0;
    end else begin
      tx_state <= tx_state_next;
      if (tx_load) o_tx_data <= tx_load_val;
    end
  end

  always_comb begin
    tx_state_next = tx_state;
    tx_load       = 1'b0;
    tx_load_val   = io_data_bus[NB_BITS-1:0];
    o_tx_start    = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (tx_wr) begin
          tx_load       = 1'b1;
          tx_state_next = TX_START;
        end
`ifdef UART_BRIDGE_ECHO_EN
        else if (i_rx_done) begin
          tx_load       = 1'b1;
          tx_load_val   = i_rx_data;
          tx_state_next = TX_START;
        end
`endif
      end
      TX_START: begin
        o_tx_start    = 1'b1;
        tx_state_next = TX_WAIT;
      end
      TX_WAIT: begin
        if (i_tx_done) tx_state_next = TX_IDLE;
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  always_comb begin
    status            = '0;
    status[0]         = ~fifo_empty;
    status[1]         = fifo_full;
    status[2]         = (tx_state != TX_IDLE);
    status[3]         = rx_overrun;
    status[4]         = tx_drop;
    status[8 +: CNT_W] = count;
  end

  always_comb begin
    rd_data = '0;
    if (sel_rx && !fifo_empty) rd_data[NB_BITS-1:0] = fifo_mem[rd_ptr];
    else if (sel_status)       rd_data = status;
  end

  assign io_data_bus = rd_cycle ? rd_data : {DATA_WIDTH{1'bz}};

endmodule

`default_nettype wire
